// File: rtl/top_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : top_pipeline
// Description : Pipelined unsigned datapath q = ((a-b)*(1+3c) - 4d) / 2,
//               modulo 2^DATA_WIDTH. One operand set per cycle, no
//               backpressure, in-order results flagged by q_valid_o.
//               Optional macro TOP_INPUT_REG_EN adds an input register stage
//               S0, raising latency from 3 to 4 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module top_pipeline #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  artsn_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  input  logic                  a_valid_i,
  input  logic                  b_valid_i,
  input  logic                  c_valid_i,
  input  logic                  d_valid_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  q_valid_o
);

  // Operands and accept strobe as seen by S1
  logic [DATA_WIDTH-1:0] a_s, b_s, c_s, d_s;
  logic                  acc_s;

`ifdef TOP_INPUT_REG_EN
  logic [DATA_WIDTH-1:0] a0_q, b0_q, c0_q, d0_q;
  logic [3:0]            vld0_q;

  // S0: register raw operands and all four qualifiers
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      a0_q   <= '0;
      b0_q   <= '0;
      c0_q   <= '0;
      d0_q   <= '0;
      vld0_q <= '0;
    end else begin
      a0_q   <= a_i;
      b0_q   <= b_i;
      c0_q   <= c_i;
      d0_q   <= d_i;
      vld0_q <= {a_valid_i, b_valid_i, c_valid_i, d_valid_i};
    end
  end

  assign a_s   = a0_q;
  assign b_s   = b0_q;
  assign c_s   = c0_q;
  assign d_s   = d0_q;
  assign acc_s = &vld0_q;
`else
  assign a_s   = a_i;
  assign b_s   = b_i;
  assign c_s   = c_i;
  assign d_s   = d_i;
  assign acc_s = a_valid_i & b_valid_i & c_valid_i & d_valid_i;
`endif

  logic [DATA_WIDTH-1:0] diff_d, m_d, f_d;
  logic [DATA_WIDTH-1:0] diff_q, m_q, f1_q;
  logic                  v1_q;
  logic [DATA_WIDTH-1:0] p_d, p_q, f2_q;
  logic                  v2_q;
  logic [DATA_WIDTH-1:0] r_d, r_q;
  logic                  v3_q;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  qv_q;

  // Next-state arithmetic for every stage; all results wrap at DATA_WIDTH
  always_comb begin
    diff_d = a_s - b_s;
    m_d    = c_s + (c_s << 1) + DATA_WIDTH'(1);
    f_d    = d_s << 2;
    p_d    = diff_q * m_q;
    r_d    = p_q - f2_q;
  end

  // S1: difference, multiplier operand and 4d
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      diff_q <= '0;
      m_q    <= '0;
      f1_q   <= '0;
      v1_q   <= 1'b0;
    end else begin
      diff_q <= diff_d;
      m_q    <= m_d;
      f1_q   <= f_d;
      v1_q   <= acc_s;
    end
  end

  // S2: truncated product and delayed 4d
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      p_q  <= '0;
      f2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      p_q  <= p_d;
      f2_q <= f1_q;
      v2_q <= v1_q;
    end
  end

  // S3: subtraction
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      r_q  <= '0;
      v3_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      v3_q <= v2_q;
    end
  end

  // Output: halve and hold the last issued result between pulses
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      q_q  <= '0;
      qv_q <= 1'b0;
    end else begin
      qv_q <= v3_q;
      if (v3_q) begin
        q_q <= r_q >> 1;
      end
    end
  end

  assign q_o       = q_q;
  assign q_valid_o = qv_q;

endmodule
`default_nettype wire

// File: tb/tb_top_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_pipeline
// Description : Scoreboard bench for top_pipeline. Stimulus pushes expected
//               results and their issue cycle; a monitor pops and compares on
//               every q_valid_o and checks q_o holds between pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_pipeline;

`ifdef TOP_INPUT_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk_i = 1'b0;
  logic        artsn_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0, c_i = '0, d_i = '0;
  logic        a_valid_i = 1'b0, b_valid_i = 1'b0, c_valid_i = 1'b0, d_valid_i = 1'b0;
  logic [31:0] q_o;
  logic        q_valid_o;

  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc[$];
  logic [31:0] last_q = '0;

  top_pipeline #(.DATA_WIDTH(32)) dut (
    .clk_i     (clk_i),
    .artsn_i   (artsn_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .c_i       (c_i),
    .d_i       (d_i),
    .a_valid_i (a_valid_i),
    .b_valid_i (b_valid_i),
    .c_valid_i (c_valid_i),
    .d_valid_i (d_valid_i),
    .q_o       (q_o),
    .q_valid_o (q_valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] a, b, c, d);
    logic [31:0] diff, m, p, r;
    diff = a - b;
    m    = 32'd1 + 32'd3 * c;
    p    = diff * m;
    r    = p - {d[29:0], 2'b00};
    return {1'b0, r[31:1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Called at #1 after a rising edge; operands are sampled on the next edge
  task automatic send(input logic [31:0] a, b, c, d, input logic [3:0] v, input logic [31:0] e);
    a_i = a; b_i = b; c_i = c; d_i = d;
    {a_valid_i, b_valid_i, c_valid_i, d_valid_i} = v;
    if (v == 4'hF) begin
      exp_q.push_back(e);
      exp_cyc.push_back(cyc);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    {a_valid_i, b_valid_i, c_valid_i, d_valid_i} = 4'h0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    idle(1);
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare each pulse against the scoreboard, and hold otherwise
  initial begin
    forever begin
      @(negedge clk_i);
      if (q_valid_o) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pulse: got q_o=0x%08h, expected no pulse", q_o);
        end else begin
          logic [31:0] e;
          int          c0;
          e  = exp_q.pop_front();
          c0 = exp_cyc.pop_front();
          check("result", q_o, e);
          check("latency", cyc - c0, LAT + 1);
        end
        last_q = q_o;
      end else begin
        check("hold", q_o, last_q);
      end
    end
  end

  initial begin
    logic [3:0]  v;
    logic [31:0] ra, rb, rc, rd;

    #12;
    check("reset_q", q_o, 32'd0);
    check("reset_valid", {31'd0, q_valid_o}, 32'd0);
    @(posedge clk_i); #1;
    artsn_i = 1'b1;
    idle(2);

    // Basic vector
    send(32'd10, 32'd4, 32'd2, 32'd3, 4'hF, 32'd15);
    drain();

    // Wrap and truncating shift, back to back
    send(32'd0, 32'd1, 32'd0, 32'd0, 4'hF, 32'h7FFF_FFFF);
    send(32'd5, 32'd0, 32'd0, 32'd0, 4'hF, 32'd2);
    // Multiplier wraps to zero
    send(32'd9, 32'd2, 32'h5555_5555, 32'd1, 4'hF, 32'h7FFF_FFFE);
    drain();

    // Partial valids must be ignored; q_o must hold
    send(32'd7, 32'd1, 32'd1, 32'd1, 4'b1000, 32'd0);
    send(32'd7, 32'd1, 32'd1, 32'd1, 4'b1110, 32'd0);
    send(32'd7, 32'd1, 32'd1, 32'd1, 4'b0111, 32'd0);
    idle(6);
    check("partial_hold", q_o, 32'h7FFF_FFFE);

    // Randomised gaps and bursts
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
      v  = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 14));
      send(ra, rb, rc, rd, v, model(ra, rb, rc, rd));
    end
    drain();

    // Reset with three transactions in flight
    send(32'd10, 32'd4, 32'd2, 32'd3, 4'hF, 32'd15);
    send(32'd0, 32'd1, 32'd0, 32'd0, 4'hF, 32'h7FFF_FFFF);
    send(32'd5, 32'd0, 32'd0, 32'd0, 4'hF, 32'd2);
    {a_valid_i, b_valid_i, c_valid_i, d_valid_i} = 4'h0;
    artsn_i = 1'b0;
    #1;
    check("midreset_q", q_o, 32'd0);
    check("midreset_valid", {31'd0, q_valid_o}, 32'd0);
    exp_q.delete();
    exp_cyc.delete();
    last_q = '0;
    @(posedge clk_i); @(posedge clk_i); #1;
    artsn_i = 1'b1;
    idle(8);
    send(32'd10, 32'd4, 32'd2, 32'd3, 4'hF, 32'd15);
    drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
